cdu_count_source: RTL

CDU_COUNT_SOURCE -- requirements
Module: cdu_count_source

---
 rtl/cdu_count_source.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cdu_count_source.sv
// Counter-drive source: queues signed count deltas and turns each one into a
// train of PCDU/MCDU request levels, paced by RATE_DIV and guarded by a watchdog.
module cdu_count_source #(
  parameter int FIFO_DEPTH = 4,
  parameter int WDOG_MAX   = 1023
) (
  input  logic        CLOCK,
  input  logic        SIM_RST,
  input  logic        VCC,
  input  logic        GND,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [11:0] CMD_DELTA,
  input  logic [7:0]  RATE_DIV,
  input  logic        CNTACK,
  output logic        PCDU,
  output logic        MCDU,
  output logic [11:0] REMAIN,
  output logic        BUSY,
  output logic        TIMEOUT
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = $clog2(WDOG_MAX + 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [WW-1:0] WDOG_ONE   = WW'(1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nx;
  logic          push;
  logic          pop;
  logic [11:0]   head;
  logic [11:0]   head_mag;
  logic          dir;
  logic          dir_nx;
  logic [11:0]   remain_nx;
  logic [7:0]    gap_cnt;
  logic [7:0]    gap_nx;
  logic [WW-1:0] wdog;
  logic [WW-1:0] wdog_nx;
  logic          timeout_nx;
  logic          unused_supply;

  // Two's-complement magnitude; -2048 maps onto 12'h800, which REMAIN can hold.
  function automatic logic [11:0] magnitude(input logic [11:0] d);
    if (d[11]) begin
      magnitude = ~d + 12'd1;
    end else begin
      magnitude = d;
    end
  endfunction

  assign unused_supply = VCC ^ GND;
  assign push          = CMD_VALID && CMD_READY;
  assign pop           = (state == LOAD);
  assign head          = mem[rd_ptr];
  assign head_mag      = magnitude(head);

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx   = state;
    remain_nx  = REMAIN;
    dir_nx     = dir;
    gap_nx     = gap_cnt;
    wdog_nx    = wdog;
    timeout_nx = TIMEOUT;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nx = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        remain_nx = head_mag;
        dir_nx    = head[11];
        wdog_nx   = '0;
        if (head_mag == 12'd0) begin
          state_nx = IDLE;
        end else begin
          state_nx = REQ;
        end
      end
      REQ: begin
        // An acknowledge on the final cycle of the watchdog window still counts.
        if (CNTACK) begin
          remain_nx = REMAIN - 12'd1;
          wdog_nx   = '0;
          if (REMAIN == 12'd1) begin
            state_nx = IDLE;
          end else begin
            state_nx = GAP;
            gap_nx   = RATE_DIV;
          end
        end else if (wdog == WDOG_LAST) begin
          timeout_nx = 1'b1;
          remain_nx  = 12'd0;
          wdog_nx    = '0;
          state_nx   = IDLE;
        end else begin
          wdog_nx = wdog + WDOG_ONE;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nx = REQ;
          wdog_nx  = '0;
        end else begin
          gap_nx = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Command storage carries data only; occupancy and pointers live below.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      mem[wr_ptr] <= CMD_DELTA;
    end
  end

  // Sequencer state, FIFO bookkeeping and all registered outputs.
  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dir       <= 1'b0;
      gap_cnt   <= 8'd0;
      wdog      <= '0;
      CMD_READY <= 1'b0;
      PCDU      <= 1'b0;
      MCDU      <= 1'b0;
      REMAIN    <= 12'd0;
      BUSY      <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      dir       <= dir_nx;
      gap_cnt   <= gap_nx;
      wdog      <= wdog_nx;
      REMAIN    <= remain_nx;
      TIMEOUT   <= timeout_nx;
      CMD_READY <= (count_nx != FULL_LEVEL);
      BUSY      <= (state_nx != IDLE) || (count_nx != '0);
      PCDU      <= (state_nx == REQ) && !dir_nx;
      MCDU      <= (state_nx == REQ) && dir_nx;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule
